adc128s_fc_model: RTL and testbench
===================================

// Module: adc128s_fc_model
// PURPOSE
//   Cycle-based behavioural model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style).
//   Four analog inputs are modelled as 12-bit input buses: left load cell, right load cell,
//   steering pot and battery.
//   Sits on the bench side of the A2D SPI bus and answers the controller's A2D interface.
//   Pipelined like the real part: each frame returns the conversion of the channel selected
//   in the previous frame.
// PARAMETERS
//   LD_LFT_CH   3'd0  channel number returning ld_cell_lft
//   LD_RGHT_CH  3'd4  channel number returning ld_cell_rght
//   STEER_CH    3'd5  channel number returning steerPot
//   BATT_CH     3'd6  channel number returning batt
//   FRAME_BITS  16    SCLK cycles per valid frame
// PORTS
//   clk           in   1   system clock; all logic on rising edge
//   rst           in   1   synchronous, active-high reset
//   SS_n          in   1   SPI slave select, active low
//   SCLK          in   1   SPI clock from master, idles high; several clk periods per half-cycle
//   MOSI          in   1   command bits from master, MSB first
//   MISO          out  1   result bits to master, MSB first
//   ld_cell_lft   in   12  analog value of left load cell
//   ld_cell_rght  in   12  analog value of right load cell
//   steerPot      in   12  analog value of steering potentiometer
//   batt          in   12  analog value of battery
// BEHAVIOUR
//   - Sync inputs: SS_n, SCLK, MOSI are each double-flopped into clk.
//     A third SCLK flop detects edges: rise = (q2 & ~q3), fall = (~q2 & q3).
//   - SS_n fall (frame start):
//     - latch result = value of the selected channel ch_sel;
//       unmapped channels (1,2,3,7) return 12'h000;
//     - load tx_shft[15:0] = {4'h0, result};
//     - clear bit counter.
//   - Frame start captures the analog inputs; input changes mid-frame do not affect the
//     current frame.
//   - SCLK rise while SS_n low: rx_shft <= {rx_shft[14:0], MOSI_sync}; bit counter
//     increments, saturating at 31.
//   - SCLK fall while SS_n low, after the first rise of the frame: tx_shft shifts left,
//     zero-fill.
//   - MISO = tx_shft[15] while SS_n low, so the master samples the MSB on the first SCLK rise.
//   - SS_n rise (frame end):
//     - if bit counter == FRAME_BITS, ch_sel <= rx_shft[13:11];
//     - otherwise the frame is discarded and ch_sel is unchanged.
//   - Other command bits are ignored.
//   - Two-frame read: frame N selects the channel, frame N+1 returns its 12-bit data in
//     bits [11:0], bits [15:12] = 0.
//   - Back-to-back frames are legal; the channel chosen in frame N+1 serves frame N+2.
//   - SCLK edges while SS_n high are ignored.
//   - If SS_n rises on the same clk as an SCLK rise, the bit counts before the frame is closed.
//   - Reset: ch_sel = LD_LFT_CH, tx_shft = 0, rx_shft = 0, bit counter = 0, MISO = 0,
//     edge flops = idle (SS_n = 1, SCLK = 1).
//   - Reset mid-frame: the frame is abandoned; the model waits for the next SS_n fall.
//   - The first frame after reset returns the ld_cell_lft value.
// CONFIGURATION
//   ADC_MISO_TRISTATE_EN:
//     - defined: MISO = 1'bz whenever SS_n (synced) is high, so the bus can be shared;
//     - undefined: MISO driven 1'b0 while SS_n is high.
//   Frame behaviour is otherwise identical.
// TESTING
//   1. rst, ld_cell_lft = 12'h300; frame MOSI = 16'h0000, then frame MOSI = 16'h0000
//      -> second frame MISO word = 16'h0300.
//   2. ld_cell_rght = 12'h2AB; frame MOSI = 16'h2000 (ch4), then any frame
//      -> MISO = 16'h02AB.
//      steerPot = 12'hE00, MOSI = 16'h2800 (ch5) -> 16'h0E00.
//   3. batt = 12'h3A0; frame MOSI = 16'h3000 (ch6), then read -> 16'h03A0.
//      Change batt to 12'h900 mid-frame -> current frame still 16'h03A0, next frame 16'h0900.
//   4. Frame MOSI = 16'h1000 (ch2, unmapped), then read -> 16'h0000.
//   5. Select ch4, then abort a ch6 frame after 8 SCLKs -> next full frame returns ld_cell_rght.
//   6. Select ch6, assert rst for 2 clks mid-frame -> next frame after reset returns ld_cell_lft.
//      MISO = 0 (or z with ADC_MISO_TRISTATE_EN) while SS_n is high.

Source files
------------

// File: rtl/adc128s_fc_model.sv
// rtl/adc128s_fc_model.sv - cycle-based ADC128S-style SPI A2D model, one frame of pipeline latency
// Optional ADC_MISO_TRISTATE_EN: release MISO to high-Z while SS_n is high.
module adc128s_fc_model #(
    parameter logic [2:0] LD_LFT_CH  = 3'd0,
    parameter logic [2:0] LD_RGHT_CH = 3'd4,
    parameter logic [2:0] STEER_CH   = 3'd5,
    parameter logic [2:0] BATT_CH    = 3'd6,
    parameter int         FRAME_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] steerPot,
    input  logic [11:0] batt
);
    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic        ss_q1, ss_q2, ss_q3;
    logic        sclk_q1, sclk_q2, sclk_q3;
    logic        mosi_q1, mosi_q2;
    logic        sync_ok, armed, rise_seen;
    logic [15:0] tx_shft, rx_shft, rx_nxt;
    logic [4:0]  bit_cnt, cnt_nxt;
    logic [2:0]  ch_sel;
    logic [11:0] result;
    logic        sclk_rise, sclk_fall, ss_fall, ss_rise, in_frame, count_rise;

    assign sclk_rise = sclk_q2 & ~sclk_q3;
    assign sclk_fall = ~sclk_q2 & sclk_q3;
    // armed is only set once SS_n has really been seen high, so a reset taken
    // mid-frame cannot turn the still-low SS_n into a fake frame start.
    assign ss_fall   = armed & ~ss_q2 & ss_q3;
    assign ss_rise   = armed & ss_q2 & ~ss_q3;
    assign in_frame  = armed & ~ss_q2;
    // A rise coincident with the closing SS_n edge still belongs to the frame.
    assign count_rise = sclk_rise & (in_frame | ss_rise);

    always_comb begin
        rx_nxt  = rx_shft;
        cnt_nxt = bit_cnt;
        if (count_rise) begin
            rx_nxt = {rx_shft[14:0], mosi_q2};
            if (bit_cnt != 5'd31)
                cnt_nxt = bit_cnt + 5'd1;
        end
    end

    always_comb begin
        result = 12'h000;
        case (ch_sel)
            LD_LFT_CH:  result = ld_cell_lft;
            LD_RGHT_CH: result = ld_cell_rght;
            STEER_CH:   result = steerPot;
            BATT_CH:    result = batt;
            default:    result = 12'h000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q1     <= 1'b1;
            ss_q2     <= 1'b1;
            ss_q3     <= 1'b1;
            sclk_q1   <= 1'b1;
            sclk_q2   <= 1'b1;
            sclk_q3   <= 1'b1;
            mosi_q1   <= 1'b0;
            mosi_q2   <= 1'b0;
            sync_ok   <= 1'b0;
            armed     <= 1'b0;
            rise_seen <= 1'b0;
            tx_shft   <= 16'h0000;
            rx_shft   <= 16'h0000;
            bit_cnt   <= 5'd0;
            ch_sel    <= LD_LFT_CH;
        end else begin
            ss_q1   <= SS_n;
            ss_q2   <= ss_q1;
            ss_q3   <= ss_q2;
            sclk_q1 <= SCLK;
            sclk_q2 <= sclk_q1;
            sclk_q3 <= sclk_q2;
            mosi_q1 <= MOSI;
            mosi_q2 <= mosi_q1;
            sync_ok <= 1'b1;
            if (sync_ok && ss_q1)
                armed <= 1'b1;

            if (ss_fall) begin
                tx_shft   <= {4'h0, result};
                bit_cnt   <= 5'd0;
                rise_seen <= 1'b0;
            end else begin
                rx_shft <= rx_nxt;
                bit_cnt <= cnt_nxt;
                if (count_rise)
                    rise_seen <= 1'b1;
                if (sclk_fall && in_frame && rise_seen)
                    tx_shft <= {tx_shft[14:0], 1'b0};
                if (ss_rise && cnt_nxt == FRAME_CNT)
                    ch_sel <= rx_nxt[13:11];
            end
        end
    end

`ifdef ADC_MISO_TRISTATE_EN
    assign MISO = ss_q2 ? 1'bz : tx_shft[15];
`else
    assign MISO = ss_q2 ? 1'b0 : tx_shft[15];
`endif

endmodule

// File: tb/tb_adc128s_fc_model.sv
// tb/tb_adc128s_fc_model.sv - scoreboard bench for adc128s_fc_model
module tb_adc128s_fc_model;
    logic        clk = 1'b0;
    logic        rst, SS_n, SCLK, MOSI;
    wire         MISO;
    logic [11:0] lft, rght, steer, batt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [2:0]  m_ch;

    localparam int H = 5;
`ifdef ADC_MISO_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    adc128s_fc_model dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ld_cell_lft(lft), .ld_cell_rght(rght), .steerPot(steer), .batt(batt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] chan_val(input logic [2:0] ch);
        if (ch == 3'd0) return lft;
        if (ch == 3'd4) return rght;
        if (ch == 3'd5) return steer;
        if (ch == 3'd6) return batt;
        return 12'h000;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Only complete 16-bit frames produce an expectation and update the channel.
    task automatic send_frame(input logic [15:0] cmd, input int nbits, input bit join_last);
        if (nbits == 16)
            exp_q.push_back({4'h0, chan_val(m_ch)});
        SS_n = 1'b0;
        wait_clks(6);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            wait_clks(H);
            SCLK = 1'b1;
            if (join_last && i == nbits - 1)
                SS_n = 1'b1;
            else
                wait_clks(H);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        wait_clks(6 + int'($urandom_range(0, 3)));
        if (nbits == 16)
            m_ch = cmd[13:11];
    endtask

    task automatic half_bits(input int n);
        for (int i = 0; i < n; i++) begin
            SCLK = 1'b0;
            MOSI = 1'($urandom_range(0, 1));
            wait_clks(H);
            SCLK = 1'b1;
            wait_clks(H);
        end
    endtask

    // Monitor: assembles the MISO word of each frame and checks it on frame close.
    logic        ss_prev = 1'b1, sclk_prev = 1'b1, mvalid = 1'b0;
    int          mbits = 0;
    logic [15:0] mword = 16'h0000;
    logic [15:0] exp_w;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            mvalid = 1'b0;
            mbits  = 0;
        end else begin
            if (!SS_n && ss_prev) begin
                total++;
                if (MISO !== MISO_IDLE) begin
                    bad++;
                    $display("FAIL idle_miso: got %b want %b", MISO, MISO_IDLE);
                end
                mbits  = 0;
                mword  = 16'h0000;
                mvalid = 1'b1;
            end
            if (SCLK && !sclk_prev && !ss_prev) begin
                mword = {mword[14:0], MISO};
                mbits++;
            end
            if (SS_n && !ss_prev) begin
                if (mvalid && mbits == 16) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL frame_word: got %h want <none queued>", mword);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (mword !== exp_w) begin
                            bad++;
                            $display("FAIL frame_word: got %h want %h", mword, exp_w);
                        end
                    end
                end
                mvalid = 1'b0;
            end
        end
        ss_prev   = SS_n;
        sclk_prev = SCLK;
    end

    initial begin
        logic [15:0] cmd;
        int          nb;
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        lft = 12'h000; rght = 12'h000; steer = 12'h000; batt = 12'h000;
        m_ch = 3'd0;
        wait_clks(4);
        total++;
        if (MISO !== MISO_IDLE) begin
            bad++;
            $display("FAIL reset_miso: got %b want %b", MISO, MISO_IDLE);
        end
        rst = 1'b0;
        wait_clks(4);

        lft = 12'h300;
        send_frame(16'h0000, 16, 1'b0);
        send_frame(16'h0000, 16, 1'b0);

        rght = 12'h2AB; steer = 12'hE00;
        send_frame(16'h2000, 16, 1'b0);
        send_frame(16'h2800, 16, 1'b0);
        send_frame(16'h0000, 16, 1'b0);

        batt = 12'h3A0;
        send_frame(16'h3000, 16, 1'b0);
        fork
            send_frame(16'h3000, 16, 1'b0);
            begin wait_clks(40); batt = 12'h900; end
        join
        send_frame(16'h0000, 16, 1'b0);

        send_frame(16'h1000, 16, 1'b0);
        send_frame(16'h0000, 16, 1'b0);

        send_frame(16'h2000, 16, 1'b0);
        send_frame(16'h3000, 8, 1'b0);
        send_frame(16'h0000, 16, 1'b0);

        send_frame(16'h2800, 16, 1'b1);
        send_frame(16'h0000, 16, 1'b0);

        send_frame(16'h3000, 16, 1'b0);
        SS_n = 1'b0;
        wait_clks(6);
        half_bits(8);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        m_ch = 3'd0;
        half_bits(8);
        SS_n = 1'b1;
        wait_clks(8);
        lft = 12'h5A5;
        send_frame(16'h3000, 16, 1'b0);
        send_frame(16'h0000, 16, 1'b0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: lft   = 12'($urandom);
                1: rght  = 12'($urandom);
                2: steer = 12'($urandom);
                default: batt = 12'($urandom);
            endcase
            cmd = 16'($urandom);
            cmd[13:11] = 3'($urandom_range(0, 7));
            nb = 16;
            if ($urandom_range(0, 4) == 0) begin
                nb = int'($urandom_range(1, 20));
                if (nb == 16) nb = 17;
            end
            send_frame(cmd, nb, ($urandom_range(0, 4) == 0));
        end

        wait_clks(10);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expect: got %0d queued want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
